prune_tile_sequencer: RTL and testbench

- Producer side of the head-pruning path.
- Takes the serial stream of signed INT Q*K partial results from the systolic array and packs them into two 4x4 tiles (32 elements).
- Presents each full tile pair to the absolute-sum/threshold block with a one-cycle enable; after TILE_PAIRS pairs, issues the compare strobe.
- Samples the returned prune decision and reports per-head completion to the attention controller.

---
 rtl/prune_tile_sequencer_if.sv | 27 ++
 rtl/prune_tile_sequencer.sv | 97 +++++++++
 tb/tb_prune_tile_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prune_tile_sequencer_if.sv
// Element stream, tile-pair bus and head-level control/status between the
// systolic-array result stream, the threshold block and the attention controller.
interface prune_tile_sequencer_if #(
    parameter int width = 8
);
    logic                   start;
    logic                   in_valid;
    logic [2*width-1:0]     in_data;
    logic                   in_ready;
    logic [64*width-1:0]    tile_bus;
    logic                   enable;
    logic                   compare_flag;
    logic                   prune_in;
    logic                   busy;
    logic                   head_done;
    logic                   head_pruned;

    modport master (
        input  start, in_valid, in_data, prune_in,
        output in_ready, tile_bus, enable, compare_flag, busy, head_done, head_pruned
    );

    modport slave (
        output start, in_valid, in_data, prune_in,
        input  in_ready, tile_bus, enable, compare_flag, busy, head_done, head_pruned
    );
endinterface

// File: rtl/prune_tile_sequencer.sv
// Packs the serial Q*K result stream into 4x4 tile pairs, strobes each full pair
// to the threshold block, then issues the compare and captures the prune decision.
module prune_tile_sequencer #(
    parameter int width         = 8,
    parameter int TILE_PAIRS    = 4,
    parameter int DECISION_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    _reset,
    prune_tile_sequencer_if.master  bus,
    output logic [2:0]              dbg_state
);
    localparam int EW = 2 * width;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_EMIT    = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;

    localparam logic [7:0] LAST_PAIR = 8'(TILE_PAIRS - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(DECISION_WAIT - 1);

    logic [2:0]          r_state;
    logic [4:0]          r_elem_cnt;
    logic [7:0]          r_pair_cnt;
    logic [3:0]          r_wait_cnt;
    logic [64*width-1:0] r_tile_bus;
    logic                r_head_pruned;
    logic                w_accept;

    // Handshake: an element transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready is a pure state decode, so it never depends on in_valid.
    assign w_accept = (r_state == S_FILL) && bus.in_valid;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state       <= S_IDLE;
            r_elem_cnt    <= '0;
            r_pair_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_tile_bus    <= '0;
            r_head_pruned <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state       <= S_FILL;
                        r_elem_cnt    <= '0;
                        r_pair_cnt    <= '0;
                        r_head_pruned <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_tile_bus[r_elem_cnt*EW +: EW] <= bus.in_data;
                        r_elem_cnt <= r_elem_cnt + 5'd1;
                        if (r_elem_cnt == 5'd31) begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    // tile_bus is untouched here; the next pair overwrites slots in order.
                    r_pair_cnt <= r_pair_cnt + 8'd1;
                    r_elem_cnt <= '0;
                    r_state    <= (r_pair_cnt == LAST_PAIR) ? S_COMPARE : S_FILL;
                end
                S_COMPARE: begin
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_head_pruned <= bus.prune_in;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from registers only, so nothing combinational reaches the outputs.
    assign bus.in_ready     = (r_state == S_FILL);
    assign bus.enable       = (r_state == S_EMIT);
    assign bus.compare_flag = (r_state == S_COMPARE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.head_done    = (r_state == S_WAIT) && (r_wait_cnt == 4'd0);
    assign bus.tile_bus     = r_tile_bus;
    assign bus.head_pruned  = r_head_pruned;
    assign dbg_state        = r_state;
endmodule

// File: tb/tb_prune_tile_sequencer.sv
// Bench for prune_tile_sequencer: one instance with a single tile pair per head and
// one with four, driven from a shared stimulus with start steered by sel.
module tb_prune_tile_sequencer;
    localparam int WIDTH = 8;
    localparam int EW    = 2 * WIDTH;
    localparam int TW    = 64 * WIDTH;
    localparam int DW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          prune_in = 1'b0;
    logic [EW-1:0] in_data = '0;
    bit            sel = 1'b0;

    always #5 clk = ~clk;

    prune_tile_sequencer_if #(.width(WIDTH)) if_a ();
    prune_tile_sequencer_if #(.width(WIDTH)) if_b ();

    assign if_a.start    = start & ~sel;
    assign if_a.in_valid = in_valid;
    assign if_a.in_data  = in_data;
    assign if_a.prune_in = prune_in;
    assign if_b.start    = start & sel;
    assign if_b.in_valid = in_valid;
    assign if_b.in_data  = in_data;
    assign if_b.prune_in = prune_in;

    logic [2:0] dbg_a, dbg_b;

    prune_tile_sequencer #(.width(WIDTH), .TILE_PAIRS(1), .DECISION_WAIT(DW)) u_dut_a (
        .clk(clk), ._reset(rst_n), .bus(if_a.master), .dbg_state(dbg_a)
    );
    prune_tile_sequencer #(.width(WIDTH), .TILE_PAIRS(4), .DECISION_WAIT(DW)) u_dut_b (
        .clk(clk), ._reset(rst_n), .bus(if_b.master), .dbg_state(dbg_b)
    );

    logic          m_ready, m_en, m_cmp, m_busy, m_done, m_pruned;
    logic [TW-1:0] m_bus;
    assign m_ready  = sel ? if_b.in_ready     : if_a.in_ready;
    assign m_en     = sel ? if_b.enable       : if_a.enable;
    assign m_cmp    = sel ? if_b.compare_flag : if_a.compare_flag;
    assign m_busy   = sel ? if_b.busy         : if_a.busy;
    assign m_done   = sel ? if_b.head_done    : if_a.head_done;
    assign m_pruned = sel ? if_b.head_pruned  : if_a.head_pruned;
    assign m_bus    = sel ? if_b.tile_bus     : if_a.tile_bus;

    typedef struct {
        bit sel;
        int mode;   // 0: index, 1: index with alternating sign, 2: random
        int gap;    // percent of cycles with in_valid low
        bit prune;
        bit ign;    // pulse start during FILL and throughout WAIT
        int np;     // expected enable pulses
        int lat;    // expected start..head_done cycles inclusive, -1 = not checked
    } vec_t;
    vec_t vecs[7];

    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] acc = '0;
    int  slot = 0;
    int  n_vec = 0, n_err = 0, cyc = 0;
    int  ready_cyc = 0, en_cnt = 0, cmp_cnt = 0, done_cnt = 0;
    int  last_acc = 0, last_en = 0, last_cmp = 0, done_cyc = 0;
    bit  accepted = 1'b0, chk_clear = 1'b0;
    bit  pruned_exp[2];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sample outputs on the falling edge and run the scoreboard.
    task automatic sample();
        logic [TW-1:0] exp_t;
        @(negedge clk);
        if (chk_clear) begin
            check("pruned_clear_on_start", int'(m_pruned), 0);
            check("busy_after_start", int'(m_busy), 1);
            chk_clear = 1'b0;
        end
        if (m_ready) ready_cyc++;
        if (in_valid && m_ready) begin
            acc[slot*EW +: EW] = in_data;
            slot++;
            last_acc = cyc;
            accepted = 1'b1;
            if (slot == 32) begin
                exp_q.push_back(acc);
                slot = 0;
            end
        end
        if (m_en) begin
            en_cnt++;
            check("enable_latency", cyc - last_acc, 1);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tile_unexpected: enable with no expected tile (cycle %0d)", cyc);
            end else begin
                exp_t = exp_q.pop_front();
                if (m_bus !== exp_t) begin
                    n_err++;
                    $display("FAIL tile_bus: got %h expected %h", m_bus, exp_t);
                end
            end
            last_en = cyc;
        end
        if (m_cmp) begin
            cmp_cnt++;
            check("compare_after_enable", cyc - last_en, 1);
            last_cmp = cyc;
        end
        if (m_done) begin
            done_cnt++;
            check("done_after_compare", cyc - last_cmp, DW);
            done_cyc = cyc;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [EW-1:0] elem(input int mode, input int i);
        case (mode)
            0:       return EW'(i);
            1:       return (i % 2 == 1) ? EW'(-i) : EW'(i);
            default: return EW'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic stream(input int n, input int mode, input int gap, input bit ign);
        int idx = 0, guard = 0, have = -1;
        logic [EW-1:0] cur = '0;
        while (idx < n && guard < 4000) begin
            if (have != idx) begin
                cur  = elem(mode, idx);
                have = idx;
            end
            in_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
            in_data  = in_valid ? cur : EW'($urandom_range(0, 65535));
            start    = ign && (idx == 10);
            accepted = 1'b0;
            sample();
            if (accepted) idx++;
            advance();
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("stream_complete", idx, n);
    endtask

    task automatic run_head(input vec_t v);
        int e0, c0, d0, r0, st, guard;
        sel      = v.sel;
        prune_in = v.prune;
        e0 = en_cnt; c0 = cmp_cnt; d0 = done_cnt; r0 = ready_cyc;
        start = 1'b1;
        sample();
        check("idle_before_start", int'(m_busy), 0);
        check("pruned_held", int'(m_pruned), int'(pruned_exp[v.sel]));
        st = cyc;
        advance();
        start     = 1'b0;
        chk_clear = 1'b1;
        stream(32 * v.np, v.mode, v.gap, v.ign);
        guard = 0;
        while (done_cnt == d0 && guard < 100) begin
            start = v.ign;
            sample();
            advance();
            guard++;
        end
        start = 1'b0;
        check("head_done_count", done_cnt - d0, 1);
        check("enable_count", en_cnt - e0, v.np);
        check("compare_count", cmp_cnt - c0, 1);
        check("queue_drained", exp_q.size(), 0);
        if (v.lat > 0) check("head_latency", done_cyc - st + 1, v.lat);
        if (v.gap == 0) check("ready_cycles", ready_cyc - r0, 32 * v.np);
        pruned_exp[v.sel] = v.prune;
    endtask

    initial begin
        int d0;
        vecs[0] = '{1'b0, 0, 0,  1'b1, 1'b0, 1, 37};
        vecs[1] = '{1'b0, 2, 0,  1'b0, 1'b0, 1, 37};
        vecs[2] = '{1'b1, 1, 0,  1'b1, 1'b0, 4, 136};
        vecs[3] = '{1'b1, 2, 50, 1'b0, 1'b0, 4, -1};
        vecs[4] = '{1'b0, 1, 50, 1'b1, 1'b0, 1, -1};
        vecs[5] = '{1'b1, 0, 0,  1'b0, 1'b1, 4, 136};
        vecs[6] = '{1'b0, 2, 0,  1'b1, 1'b1, 1, 37};
        pruned_exp[0] = 1'b0;
        pruned_exp[1] = 1'b0;

        repeat (3) advance();
        sample();
        check("rst_tile_bus_a", int'(if_a.tile_bus != '0), 0);
        check("rst_tile_bus_b", int'(if_b.tile_bus != '0), 0);
        check("rst_in_ready", int'(if_a.in_ready | if_b.in_ready), 0);
        check("rst_strobes", int'(if_a.enable | if_a.compare_flag | if_b.enable | if_b.compare_flag), 0);
        check("rst_busy_done", int'(if_a.busy | if_a.head_done | if_b.busy | if_b.head_done), 0);
        check("rst_pruned", int'(if_a.head_pruned | if_b.head_pruned), 0);
        advance();
        rst_n = 1'b1;
        repeat (2) begin
            sample();
            advance();
        end

        for (int i = 0; i < 7; i++) run_head(vecs[i]);

        // Abandon a four-pair head 20 elements into its second pair.
        sel = 1'b1;
        prune_in = 1'b1;
        d0 = done_cnt;
        start = 1'b1;
        sample();
        advance();
        start = 1'b0;
        chk_clear = 1'b1;
        stream(52, 0, 0, 1'b0);
        rst_n = 1'b0;
        sample();
        check("midrst_state", int'(dbg_b), 0);
        check("midrst_outputs", int'(if_b.in_ready | if_b.busy | if_b.enable | if_b.head_done), 0);
        check("midrst_tile_bus", int'(if_b.tile_bus != '0), 0);
        check("midrst_pruned", int'(if_b.head_pruned), 0);
        advance();
        rst_n = 1'b1;
        slot = 0;
        exp_q.delete();
        pruned_exp[0] = 1'b0;
        pruned_exp[1] = 1'b0;
        repeat (5) begin
            sample();
            advance();
        end
        check("midrst_no_head_done", done_cnt - d0, 0);
        run_head(vecs[2]);

        sample();
        check("final_pruned", int'(m_pruned), int'(pruned_exp[sel]));
        check("final_idle", int'(m_busy), 0);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
